float_point_normalize_round: RTL and testbench

Final stage after the float_point_multiply mantissa/exponent datapath. Consumes the raw product fields: sign, biased exponent sum, 48-bit 24x24 significand product and a special-case code. Produces the packed IEEE-754 single-precision result. Two-stage pipeline with valid/ready handshake on both sides, round-to-nearest-even, no denormal support (flush to zero).

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_rne_round.sv | 30 +++
 rtl/float_point_normalize_round.sv | 145 ++++++++++++++
 tb/tb_float_point_normalize_round.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and the stage-1 record for the float_point_normalize_round pipeline.
package fp_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  localparam int FP_FRAC_W = 23;
  // Wide enough to carry the signed exponent through the +1 from normalize and rounding.
  localparam int FP_SEXP_W = 12;

  localparam logic [1:0] FP_NORM = 2'b00;
  localparam logic [1:0] FP_ZERO = 2'b01;
  localparam logic [1:0] FP_INF  = 2'b10;
  localparam logic [1:0] FP_NAN  = 2'b11;

  typedef struct packed {
    logic                 sign;
    logic [FP_SEXP_W-1:0] exp;
    logic [FP_FRAC_W-1:0] frac;
    logic                 guard;
    logic                 sticky;
    logic [1:0]           special;
  } fp_s1_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a normalized fraction, with overflow/flush-to-zero detection.
module fp_rne_round
  import fp_pkg::*;
(
  input  logic [FP_FRAC_W-1:0] fracIn,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic [FP_SEXP_W-1:0] expIn,
  output logic [FP_FRAC_W-1:0] fracOut,
  output logic [7:0]           expOut,
  output logic                 overflow,
  output logic                 underflow
);

  logic                 roundUp;
  logic [FP_FRAC_W:0]   sum;
  logic [FP_SEXP_W-1:0] expRounded;

  // A carry out of the fraction leaves it all-zero, which is exactly 1.0 at the next exponent.
  always_comb begin
    roundUp    = guard & (sticky | fracIn[0]);
    sum        = {1'b0, fracIn} + {{FP_FRAC_W{1'b0}}, roundUp};
    fracOut    = sum[FP_FRAC_W-1:0];
    expRounded = expIn + {{(FP_SEXP_W-1){1'b0}}, sum[FP_FRAC_W]};
    expOut     = expRounded[7:0];
    overflow   = $signed(expRounded) >= $signed(FP_SEXP_W'(FP_EXP_MAX));
    underflow  = !overflow && ($signed(expRounded) <= $signed(FP_SEXP_W'(0)));
  end

endmodule

// File: rtl/float_point_normalize_round.sv
// Two-stage normalize/round/pack of a 24x24 significand product into IEEE-754 single.
// Optional macro FP_ROUND_FLAGS_EN adds the oFlags {invalid,overflow,underflow,inexact} output.
module float_point_normalize_round
  import fp_pkg::*;
#(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 48
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iSign,
  input  logic [EXP_W-1:0]  iExp,
  input  logic [MANT_W-1:0] iMant,
  input  logic [1:0]        iSpecial,
  output logic              oValid,
  input  logic              iReady,
  output logic [31:0]       oZ
`ifdef FP_ROUND_FLAGS_EN
  ,
  output logic [3:0]        oFlags
`endif
);

  fp_s1_t               s1Next;
  fp_s1_t               s1Data;
  logic                 s1Valid;
  logic                 s2Load;
  logic [FP_SEXP_W-1:0] expExt;

  logic [FP_FRAC_W-1:0] fracRounded;
  logic [7:0]           expRounded;
  logic                 overflow;
  logic                 underflow;
  logic [31:0]          zNext;
`ifdef FP_ROUND_FLAGS_EN
  logic [3:0]           flagsNext;
`endif

  assign s2Load = !oValid || iReady;
  assign oReady = !s1Valid || s2Load;

  // A product in [2,4) needs a one-bit right shift; otherwise the hidden bit sits at MANT_W-2.
  always_comb begin
    expExt         = {{(FP_SEXP_W-EXP_W){iExp[EXP_W-1]}}, iExp};
    s1Next         = '0;
    s1Next.sign    = iSign;
    s1Next.special = iSpecial;
    if (iMant[MANT_W-1]) begin
      s1Next.frac   = iMant[MANT_W-2 -: FP_FRAC_W];
      s1Next.guard  = iMant[MANT_W-2-FP_FRAC_W];
      s1Next.sticky = |iMant[MANT_W-3-FP_FRAC_W:0];
      s1Next.exp    = expExt + FP_SEXP_W'(1);
    end else begin
      s1Next.frac   = iMant[MANT_W-3 -: FP_FRAC_W];
      s1Next.guard  = iMant[MANT_W-3-FP_FRAC_W];
      s1Next.sticky = |iMant[MANT_W-4-FP_FRAC_W:0];
      s1Next.exp    = expExt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
    end else if (oReady) begin
      s1Valid <= iValid;
      if (iValid) begin
        s1Data <= s1Next;
      end
    end
  end

  fp_rne_round uRound (
    .fracIn    (s1Data.frac),
    .guard     (s1Data.guard),
    .sticky    (s1Data.sticky),
    .expIn     (s1Data.exp),
    .fracOut   (fracRounded),
    .expOut    (expRounded),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Special codes bypass rounding entirely; NaN is always the canonical positive quiet NaN.
  always_comb begin
    zNext = {s1Data.sign, expRounded, fracRounded};
`ifdef FP_ROUND_FLAGS_EN
    flagsNext = {3'b000, s1Data.guard | s1Data.sticky};
`endif
    case (s1Data.special)
      FP_ZERO: begin
        zNext = {s1Data.sign, 31'h0};
`ifdef FP_ROUND_FLAGS_EN
        flagsNext = 4'b0000;
`endif
      end
      FP_INF: begin
        zNext = {s1Data.sign, 8'hFF, 23'h0};
`ifdef FP_ROUND_FLAGS_EN
        flagsNext = 4'b0000;
`endif
      end
      FP_NAN: begin
        zNext = FP_QNAN;
`ifdef FP_ROUND_FLAGS_EN
        flagsNext = 4'b1000;
`endif
      end
      default: begin
        if (overflow) begin
          zNext = {s1Data.sign, 8'hFF, 23'h0};
`ifdef FP_ROUND_FLAGS_EN
          flagsNext = 4'b0101;
`endif
        end else if (underflow) begin
          zNext = {s1Data.sign, 31'h0};
`ifdef FP_ROUND_FLAGS_EN
          flagsNext = 4'b0011;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oValid <= 1'b0;
      oZ     <= 32'h0;
`ifdef FP_ROUND_FLAGS_EN
      oFlags <= 4'h0;
`endif
    end else if (s2Load) begin
      oValid <= s1Valid;
      if (s1Valid) begin
        oZ <= zNext;
`ifdef FP_ROUND_FLAGS_EN
        oFlags <= flagsNext;
`endif
      end
    end
  end

endmodule

// File: tb/tb_float_point_normalize_round.sv
// Directed plus randomized bench for float_point_normalize_round with a scoreboard reference.
// Build with FP_ROUND_FLAGS_EN defined to also check oFlags.
module tb_float_point_normalize_round;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iValid;
  logic        oReady;
  logic        iSign;
  logic [9:0]  iExp;
  logic [47:0] iMant;
  logic [1:0]  iSpecial;
  logic        oValid;
  logic        iReady;
  logic [31:0] oZ;
`ifdef FP_ROUND_FLAGS_EN
  logic [3:0]  oFlags;
`endif

  int tests  = 0;
  int failed = 0;
  logic [35:0] expQ[$];

  always #5 clk = ~clk;

  float_point_normalize_round dut (
    .clk      (clk),
    .resetn   (resetn),
    .iValid   (iValid),
    .oReady   (oReady),
    .iSign    (iSign),
    .iExp     (iExp),
    .iMant    (iMant),
    .iSpecial (iSpecial),
    .oValid   (oValid),
    .iReady   (iReady),
    .oZ       (oZ)
`ifdef FP_ROUND_FLAGS_EN
    ,
    .oFlags   (oFlags)
`endif
  );

  // Reference: take the top 24 significant bits as an integer, round the discarded remainder
  // against exactly half, then range-check the final exponent.
  function automatic logic [35:0] refModel(bit sgn, int e, logic [47:0] m, logic [1:0] sp);
    longint unsigned mu, keep, rem, half;
    int          sh, ex;
    bit          up;
    logic [31:0] z;
    logic [3:0]  f;
    case (sp)
      2'b01:   begin z = {sgn, 31'h0};         f = 4'b0000; end
      2'b10:   begin z = {sgn, 8'hFF, 23'h0};  f = 4'b0000; end
      2'b11:   begin z = 32'h7FC00000;         f = 4'b1000; end
      default: begin
        sh   = m[47] ? 24 : 23;
        ex   = m[47] ? e + 1 : e;
        mu   = 64'(m);
        keep = mu >> sh;
        rem  = mu - (keep << sh);
        half = 64'd1 << (sh - 1);
        up   = (rem > half) || (rem == half && keep[0]);
        keep = keep + 64'(up);
        if (keep == (64'd1 << 24)) begin
          keep = keep >> 1;
          ex   = ex + 1;
        end
        if (ex >= 255) begin
          z = {sgn, 8'hFF, 23'h0}; f = 4'b0101;
        end else if (ex <= 0) begin
          z = {sgn, 31'h0}; f = 4'b0011;
        end else begin
          z = {sgn, ex[7:0], keep[22:0]}; f = {3'b000, rem != 0};
        end
      end
    endcase
    return {f, z};
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(bit v, bit s, int e, logic [47:0] m, logic [1:0] sp);
    iValid   = v;
    iSign    = s;
    iExp     = e[9:0];
    iMant    = m;
    iSpecial = sp;
  endtask

  // Called just after a falling edge; records transfers shortly before the next rising edge.
  task automatic step();
    logic [35:0] refVal;
    #3;
    if (oValid && iReady) begin
      checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        refVal = expQ.pop_front();
        checkOutput("sb_z", oZ, refVal[31:0]);
`ifdef FP_ROUND_FLAGS_EN
        checkOutput("sb_flags", {28'h0, oFlags}, {28'h0, refVal[35:32]});
`endif
      end
    end
    if (iValid && oReady)
      expQ.push_back(refModel(iSign, int'($signed(iExp)), iMant, iSpecial));
    @(negedge clk);
  endtask

  task automatic runOne(string tag, bit s, int e, logic [47:0] m, logic [1:0] sp,
                        logic [31:0] expZ, logic [3:0] expF);
    iReady = 1'b1;
    applyStimulus(1'b1, s, e, m, sp);
    step();
    applyStimulus(1'b0, 1'b0, 0, 48'h0, 2'b00);
    checkOutput({tag, "_lat1"}, 32'(oValid), 32'd0);
    step();
    checkOutput({tag, "_valid"}, 32'(oValid), 32'd1);
    checkOutput({tag, "_z"}, oZ, expZ);
`ifdef FP_ROUND_FLAGS_EN
    checkOutput({tag, "_flags"}, {28'h0, oFlags}, {28'h0, expF});
`else
    if (expF == 4'hF) $display("[TB] note: unused flag pattern");
`endif
    step();
  endtask

  task automatic randomOp(output bit s, output int e, output logic [47:0] m, output logic [1:0] sp);
    int eA, eB;
    s  = 1'($urandom_range(0, 1));
    eA = int'($urandom_range(1, 254));
    eB = int'($urandom_range(1, 254));
    e  = eA + eB - FP_BIAS;
    m  = {$urandom, $urandom};
    if (!m[47]) m[46] = 1'b1;
    if ($urandom_range(0, 3) == 0) begin
      if (m[47]) m[23:0] = 24'h800000;
      else       m[22:0] = 23'h400000;
    end
    sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endtask

  initial begin
    bit          s;
    int          e;
    logic [47:0] m;
    logic [1:0]  sp;

    resetn = 1'b0;
    iReady = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 48'h0, 2'b00);
    #2;
    checkOutput("reset_valid", 32'(oValid), 32'd0);
    checkOutput("reset_z", oZ, 32'h0);
    checkOutput("reset_ready", 32'(oReady), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    runOne("mul12p5x8p5", 1'b0, 133, 48'h6A40_0000_0000, 2'b00, 32'h42D48000, 4'b0000);
    runOne("ovf_shift",   1'b0, 254, 48'h8000_0000_0000, 2'b00, 32'h7F800000, 4'b0101);
    runOne("tie_carry",   1'b0, 127, 48'h7FFF_FFC0_0000, 2'b00, 32'h40000000, 4'b0001);
    runOne("tie_even",    1'b0, 127, 48'h7FFF_FF40_0000, 2'b00, 32'h3FFFFFFE, 4'b0001);
    runOne("underflow",   1'b1, 0,   48'h4000_0000_0000, 2'b00, 32'h80000000, 4'b0011);
    runOne("nan",         1'b1, 5,   48'h4000_0000_0000, 2'b11, 32'h7FC00000, 4'b1000);
    runOne("neg_inf",     1'b1, 5,   48'h4000_0000_0000, 2'b10, 32'hFF800000, 4'b0000);
    runOne("zero",        1'b1, 200, 48'h4000_0000_0000, 2'b01, 32'h80000000, 4'b0000);

    // Backpressure: two ops fill the pipe, the third must wait.
    iReady = 1'b0;
    randomOp(s, e, m, sp); applyStimulus(1'b1, s, e, m, 2'b00); step();
    randomOp(s, e, m, sp); applyStimulus(1'b1, s, e, m, 2'b00); step();
    randomOp(s, e, m, sp); applyStimulus(1'b1, s, e, m, 2'b00);
    checkOutput("bp_ready_low", 32'(oReady), 32'd0);
    step();
    step();
    checkOutput("bp_valid_held", 32'(oValid), 32'd1);
    checkOutput("bp_z_held", oZ, expQ[0][31:0]);
    checkOutput("bp_queued", 32'(expQ.size()), 32'd2);
    iReady = 1'b1;
    step();
    iValid = 1'b0;
    checkOutput("bp_stream1", 32'(oValid), 32'd1);
    step();
    checkOutput("bp_stream2", 32'(oValid), 32'd1);
    step();
    checkOutput("bp_drained", 32'(oValid), 32'd0);
    checkOutput("bp_queue_empty", 32'(expQ.size()), 32'd0);

    // Reset with both stages occupied.
    iReady = 1'b0;
    randomOp(s, e, m, sp); applyStimulus(1'b1, s, e, m, sp); step();
    randomOp(s, e, m, sp); applyStimulus(1'b1, s, e, m, sp); step();
    iValid = 1'b0;
    checkOutput("rst_full", 32'(oValid), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(oValid), 32'd0);
    checkOutput("rst_async_z", oZ, 32'h0);
    checkOutput("rst_async_ready", 32'(oReady), 32'd1);
    expQ.delete();
    @(negedge clk);
    resetn = 1'b1;
    iReady = 1'b1;
    step();
    step();
    checkOutput("rst_no_stale", 32'(oValid), 32'd0);

    // Randomized traffic with random downstream stalls.
    for (int n = 0; n < 400; n++) begin
      iReady = ($urandom_range(0, 3) != 0);
      randomOp(s, e, m, sp);
      applyStimulus(1'($urandom_range(0, 4) != 0), s, e, m, sp);
      step();
    end
    iValid = 1'b0;
    iReady = 1'b1;
    for (int n = 0; n < 20 && expQ.size() != 0; n++) step();
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
